vendor_panel_arbiter: RTL and testbench
=======================================

# vendor_panel_arbiter

Shares one AutoVendor core between two customer panels, panel 0 and panel 1. Only one panel owns the core at a time. The arbiter grants a session, forwards that panel's coin and selection codes to the core, and watches the core outputs for the end of the transaction. It forces a cancel on abandoned sessions and then hands the core to the other panel in round-robin order. It sits between the panel input logic and the AutoVendor core.

## Interface
- TIMEOUT, 16: idle cycles allowed in SESSION before the arbiter acts; range 1..255.
- WAIT_LIMIT, 8: cycles allowed in WAIT_DONE for the core to respond; range 1..255.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- p0_money, p1_money  in  8 each  panel coin code: 0 none, 1/5/10/50 coin, 2 cancel.
- p0_choose, p1_choose  in  4 each  panel selection: 0 none, 1 tea, 2 cola, 3 coffee, 4 milk.
- core_give  in  4  core dispense output.
- core_change  in  8  core change output.
- core_total  in  8  core credit total.
- core_money  out  8  coin code to the core; registered.
- core_choose  out  4  selection to the core; registered.
- grant  out  2  one-hot; marks the current session owner.
- busy  out  2  busy[i]=1 while the other panel owns the core.
- done_pulse  out  1  one-cycle pulse when a transaction completes normally.
- timeout_pulse  out  1  one-cycle pulse on a forced cancel or a WAIT_LIMIT expiry.

## Operation
- States: IDLE, SESSION, FORCE_CANCEL, WAIT_DONE, RELEASE.
- Request definition: panel i requests when pi_money != 0 or pi_choose != 0.
- IDLE:
  - Outputs are 0.
  - If one panel requests, grant it.
  - If both request, grant the panel that was not granted last. The last-grant pointer resets to 1, so panel 0 wins the first tie.
  - On the grant cycle, register the triggering codes into core_money/core_choose so the first coin is not lost. Go to SESSION.
- SESSION:
  - Each cycle: core_money <= owner money, core_choose <= owner choose.
  - Inputs from the non-owner are ignored and not queued; that panel must re-present its request after release.
  - Idle counter clears on any nonzero owner input and increments otherwise.
  - Owner choose != 0 → WAIT_DONE, with core_choose latched to that value.
  - Owner money == 2 (cancel) → WAIT_DONE, with core_choose = 0.
  - Idle counter reaches TIMEOUT with core_total == 0 → RELEASE.
  - Idle counter reaches TIMEOUT with core_total != 0 → FORCE_CANCEL.
- FORCE_CANCEL: drive core_money = 2 for exactly one cycle, pulse timeout_pulse, go to WAIT_DONE.
- WAIT_DONE:
  - core_money = 0; core_choose holds its latched value.
  - Owner inputs are ignored.
  - core_give != 0 or core_change != 0 → pulse done_pulse, go to RELEASE.
  - After a cancel, core_total == 0 is also a valid completion condition.
  - WAIT_LIMIT cycles with no completion → pulse timeout_pulse, go to RELEASE. This covers insufficient credit.
- RELEASE: one cycle. core_money/core_choose = 0, grant = 0, last-grant pointer = previous owner, go to IDLE.
- busy follows grant: busy = {grant[0], grant[1]}.

## Timing
- Reset (asynchronous, active-low): state = IDLE, and every output is 0 (core_money, core_choose, grant, busy, done_pulse, timeout_pulse). Counters clear and the pointer is set to 1.
- Reset asserted mid-session drops the core inputs to 0 immediately. Recovering any credit held in the core is the core's own reset responsibility.
- Forwarding latency: a panel code at edge N appears on core_money/core_choose at edge N+1.
- grant rises on the edge after the first request is sampled, in the same cycle as the first forwarded code.
- Minimum gap between sessions: 1 RELEASE cycle plus 1 IDLE cycle. A request held through RELEASE is granted at the first IDLE evaluation.
- done_pulse and timeout_pulse never assert in the same cycle. A core completion in the last WAIT_LIMIT cycle counts as done.
- Idle and wait counters are 8 bits and saturate; they clear on every state entry.

## Test plan
- Panel 0 sends 10, 1, 10, then 0, then choose=3 for 3 cycles.
  - core_money shows 10, 1, 10 each one cycle late.
  - core_choose=3 is latched and held; core_give=3 → done_pulse, then RELEASE.
  - grant=01 throughout; busy=10.
- Both panels request in the same cycle after reset → panel 0 is granted. After its release, both request again → panel 1 is granted.
- Panel 1 sends 5, 10, then 2.
  - WAIT_DONE is entered; core_change=15 → done_pulse, then back to IDLE.
  - Panel 0's coin sent during panel 1's session never reaches the core.
- Panel 0 sends 10, then goes silent with TIMEOUT=16 and core_total=10.
  - After 16 idle cycles, core_money=2 for one cycle and timeout_pulse fires.
  - core_change=10 → done_pulse.
- Choose=4 with core_total=10 and the core never responding → after WAIT_LIMIT=8 cycles, timeout_pulse fires and the arbiter releases.
- Reset driven low mid-SESSION → all outputs 0 at once. After reset is released, a panel 1 request is granted normally.

Source files
------------

// File: rtl/vendor_panel_arbiter.sv
// vendor_panel_arbiter: gives one shared AutoVendor core to one of two panels at a time, in round-robin order.
// It forwards the owner's codes one cycle late and forces a cancel when a session holding credit is abandoned.
module vendor_panel_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] p0_money,
  input  logic [7:0] p1_money,
  input  logic [3:0] p0_choose,
  input  logic [3:0] p1_choose,
  input  logic [3:0] core_give,
  input  logic [7:0] core_change,
  input  logic [7:0] core_total,
  output logic [7:0] core_money,
  output logic [3:0] core_choose,
  output logic [1:0] grant,
  output logic [1:0] busy,
  output logic       done_pulse,
  output logic       timeout_pulse
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SESSION      = 3'd1,
    FORCE_CANCEL = 3'd2,
    WAIT_DONE    = 3'd3,
    RELEASE      = 3'd4
  } state_t;

  localparam logic [8:0] TIMEOUT_W   = 9'(TIMEOUT);
  localparam logic [8:0] WAIT_W      = 9'(WAIT_LIMIT);
  localparam logic [7:0] CODE_CANCEL = 8'd2;

  state_t     state_r, state_s;
  logic       owner_r, owner_s, last_r, last_s, cancel_r, cancel_s;
  logic [7:0] idle_cnt_r, idle_cnt_s, wait_cnt_r, wait_cnt_s;
  logic [7:0] money_s, own_money_s;
  logic [3:0] choose_s, own_choose_s;
  logic [1:0] grant_s;
  logic       active_s, done_s, tmo_s;
  logic       req0_s, req1_s, own_quiet_s, core_done_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req0_s       = (p0_money != 8'd0) || (p0_choose != 4'd0);
  assign req1_s       = (p1_money != 8'd0) || (p1_choose != 4'd0);
  assign own_money_s  = owner_r ? p1_money : p0_money;
  assign own_choose_s = owner_r ? p1_choose : p0_choose;
  assign own_quiet_s  = (own_money_s == 8'd0) && (own_choose_s == 4'd0);
  // After a cancel, an emptied credit total also counts as the core finishing.
  assign core_done_s  = (core_give != 4'd0) || (core_change != 8'd0) ||
                        (cancel_r && (core_total == 8'd0));
  assign grant_s      = active_s ? (owner_s ? 2'b10 : 2'b01) : 2'b00;

  // Next state and the values the output registers take on the coming edge
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    last_s     = last_r;
    cancel_s   = cancel_r;
    idle_cnt_s = 8'd0;
    wait_cnt_s = 8'd0;
    money_s    = 8'd0;
    choose_s   = 4'd0;
    active_s   = 1'b0;
    done_s     = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          owner_s  = (req0_s && req1_s) ? ~last_r : req1_s;
          money_s  = owner_s ? p1_money : p0_money;
          choose_s = owner_s ? p1_choose : p0_choose;
          active_s = 1'b1;
          cancel_s = 1'b0;
          state_s  = SESSION;
        end else begin
          state_s = IDLE;
        end
      end
      SESSION: begin
        active_s = 1'b1;
        money_s  = own_money_s;
        choose_s = own_choose_s;
        if (own_choose_s != 4'd0) begin
          cancel_s = (own_money_s == CODE_CANCEL);
          state_s  = WAIT_DONE;
        end else if (own_money_s == CODE_CANCEL) begin
          cancel_s = 1'b1;
          state_s  = WAIT_DONE;
        end else if (!own_quiet_s) begin
          idle_cnt_s = 8'd0;
        end else if (({1'b0, idle_cnt_r} + 9'd1) >= TIMEOUT_W) begin
          if (core_total == 8'd0) begin
            active_s = 1'b0;
            state_s  = RELEASE;
          end else begin
            money_s  = CODE_CANCEL;
            tmo_s    = 1'b1;
            cancel_s = 1'b1;
            state_s  = FORCE_CANCEL;
          end
        end else begin
          idle_cnt_s = sat_inc(idle_cnt_r);
        end
      end
      FORCE_CANCEL: begin
        active_s = 1'b1;
        state_s  = WAIT_DONE;
      end
      WAIT_DONE: begin
        active_s = 1'b1;
        choose_s = core_choose;
        if (core_done_s) begin
          done_s   = 1'b1;
          active_s = 1'b0;
          choose_s = 4'd0;
          state_s  = RELEASE;
        end else if (({1'b0, wait_cnt_r} + 9'd1) >= WAIT_W) begin
          tmo_s    = 1'b1;
          active_s = 1'b0;
          choose_s = 4'd0;
          state_s  = RELEASE;
        end else begin
          wait_cnt_s = sat_inc(wait_cnt_r);
        end
      end
      RELEASE: begin
        last_s  = owner_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, round-robin pointer and every registered output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      owner_r       <= 1'b0;
      last_r        <= 1'b1;
      cancel_r      <= 1'b0;
      idle_cnt_r    <= 8'd0;
      wait_cnt_r    <= 8'd0;
      core_money    <= 8'd0;
      core_choose   <= 4'd0;
      grant         <= 2'b00;
      busy          <= 2'b00;
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_r       <= state_s;
      owner_r       <= owner_s;
      last_r        <= last_s;
      cancel_r      <= cancel_s;
      idle_cnt_r    <= idle_cnt_s;
      wait_cnt_r    <= wait_cnt_s;
      core_money    <= money_s;
      core_choose   <= choose_s;
      grant         <= grant_s;
      busy          <= {grant_s[0], grant_s[1]};
      done_pulse    <= done_s;
      timeout_pulse <= tmo_s;
    end
  end

endmodule

// File: tb/tb_vendor_panel_arbiter.sv
// Bench for vendor_panel_arbiter: session-level reference model pushes timed expected events into a queue;
// a monitor pops and compares them whenever the DUT shows a grant, a code, a pulse or a release.
module tb_vendor_panel_arbiter;
  localparam int TIMEOUT    = 16;
  localparam int WAIT_LIMIT = 8;

  localparam logic [2:0] EV_GRANT  = 3'd0;
  localparam logic [2:0] EV_MONEY  = 3'd1;
  localparam logic [2:0] EV_CHOOSE = 3'd2;
  localparam logic [2:0] EV_PULSE  = 3'd3;
  localparam logic [2:0] EV_REL    = 3'd4;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] val;
    int         stamp;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] p0_money = 8'd0, p1_money = 8'd0;
  logic [3:0] p0_choose = 4'd0, p1_choose = 4'd0;
  logic [3:0] core_give = 4'd0;
  logic [7:0] core_change = 8'd0, core_total = 8'd0;
  logic [7:0] core_money;
  logic [3:0] core_choose;
  logic [1:0] grant, busy;
  logic       done_pulse, timeout_pulse;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_own = 1;
  bit  drv_done = 1'b0;

  vendor_panel_arbiter #(.TIMEOUT(TIMEOUT), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_money(p0_money), .p1_money(p1_money), .p0_choose(p0_choose), .p1_choose(p1_choose),
    .core_give(core_give), .core_change(core_change), .core_total(core_total),
    .core_money(core_money), .core_choose(core_choose), .grant(grant), .busy(busy),
    .done_pulse(done_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input logic [2:0] k);
    case (k)
      EV_GRANT:  return "grant";
      EV_MONEY:  return "core_money";
      EV_CHOOSE: return "core_choose";
      EV_PULSE:  return "pulse";
      EV_REL:    return "release";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [7:0] pick_coin();
    case ($urandom_range(0, 3))
      0:       return 8'd1;
      1:       return 8'd5;
      2:       return 8'd10;
      default: return 8'd50;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] v, input int st);
    ev_t e;
    e.kind = k; e.val = v; e.stamp = st;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [2:0] k, input logic [7:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event value=%0d at cycle %0d, nothing expected", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v || e.stamp != cyc)
        begin
          bad++;
          $display("FAIL %s: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                   kname(e.kind), kname(k), v, cyc, kname(e.kind), e.val, e.stamp);
        end
    end
  endtask

  task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_core_money"}, core_money, 8'd0);
    check_val({tag, "_core_choose"}, {4'd0, core_choose}, 8'd0);
    check_val({tag, "_grant"}, {6'd0, grant}, 8'd0);
    check_val({tag, "_busy"}, {6'd0, busy}, 8'd0);
    check_val({tag, "_done_pulse"}, {7'd0, done_pulse}, 8'd0);
    check_val({tag, "_timeout_pulse"}, {7'd0, timeout_pulse}, 8'd0);
  endtask

  task automatic drive(input int p, input logic [7:0] m, input logic [3:0] c);
    if (p == 0) begin
      p0_money = m; p0_choose = c;
    end else begin
      p1_money = m; p1_choose = c;
    end
  endtask

  // {busy, grant} as seen when panel own holds the core
  function automatic logic [7:0] grant_code(input int own);
    return (own == 0) ? 8'h09 : 8'h06;
  endfunction

  // kind 0: purchase (core_give), kind 1: cancel (core_change, or total drop when alt)
  task automatic wait_phase(input int kind, input int own, input logic [3:0] ch, input int hold,
                            input int d, input logic [7:0] sum, input bit alt);
    int base;
    base = cyc;
    if (d <= WAIT_LIMIT) push(EV_PULSE, 8'd2, base + d);
    else push(EV_PULSE, 8'd1, base + WAIT_LIMIT);
    push(EV_REL, 8'd0, (d <= WAIT_LIMIT) ? base + d : base + WAIT_LIMIT);
    for (int e = 1; e <= WAIT_LIMIT; e++) begin
      drive(own, 8'd0, (kind == 0 && e < hold) ? ch : 4'd0);
      if (e == d) begin
        if (kind == 0) core_give = ch;
        else if (alt) core_total = 8'd0;
        else core_change = sum;
      end
      step();
      if (e == d) break;
    end
  endtask

  // kind 0 purchase, 1 cancel, 2 abandon (alt: core holds no credit)
  task automatic session(input bit tie, input int req_p, input int ncoin,
                         input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input int maxgap, input int end_gap, input int kind, input logic [3:0] ch,
                         input int hold, input int d, input bit alt);
    int own, gap, base;
    logic [7:0] coin[3];
    logic [7:0] sum;
    coin[0] = c0; coin[1] = c1; coin[2] = c2;
    own = tie ? 1 - last_own : req_p;
    core_total = 8'd0;
    drive(own, coin[0], 4'd0);
    if (tie) drive(1 - own, 8'd50, 4'd1);
    push(EV_GRANT, grant_code(own), cyc + 1);
    push(EV_MONEY, coin[0], cyc + 1);
    sum = coin[0];
    step();
    core_total = sum;
    for (int i = 1; i < ncoin; i++) begin
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        drive(own, 8'd0, 4'd0);
        drive(1 - own, 8'd10, 4'd0);
        step();
      end
      drive(own, coin[i], 4'd0);
      drive(1 - own, 8'd10, 4'd2);
      push(EV_MONEY, coin[i], cyc + 1);
      sum = sum + coin[i];
      step();
      core_total = sum;
    end
    drive(1 - own, 8'd0, 4'd0);
    drive(own, 8'd0, 4'd0);
    if (kind == 2) begin
      core_total = alt ? 8'd0 : sum;
      base = cyc;
      if (alt) push(EV_REL, 8'd0, base + TIMEOUT);
      else begin
        push(EV_MONEY, 8'd2, base + TIMEOUT);
        push(EV_PULSE, 8'd1, base + TIMEOUT);
      end
      repeat (TIMEOUT) step();
      if (!alt) begin
        step();
        wait_phase(1, own, 4'd0, 0, d, sum, 1'b0);
      end
    end else begin
      repeat (end_gap) step();
      if (kind == 0) begin
        drive(own, 8'd0, ch);
        push(EV_CHOOSE, {4'd0, ch}, cyc + 1);
      end else begin
        drive(own, 8'd2, 4'd0);
        push(EV_MONEY, 8'd2, cyc + 1);
      end
      step();
      wait_phase(kind, own, ch, hold, d, sum, alt);
    end
    drive(own, 8'd0, 4'd0);
    core_give = 4'd0; core_change = 8'd0; core_total = 8'd0;
    step();
    last_own = own;
  endtask

  task automatic monitor();
    logic [1:0] pg;
    logic [3:0] pc;
    pg = 2'b00; pc = 4'd0;
    while (!drv_done) begin
      @(negedge clk);
      if (pg == 2'b00 && grant != 2'b00) check_ev(EV_GRANT, {4'd0, busy, grant});
      if (core_money != 8'd0) check_ev(EV_MONEY, core_money);
      if (core_choose != 4'd0 && core_choose != pc) check_ev(EV_CHOOSE, {4'd0, core_choose});
      if (done_pulse || timeout_pulse) check_ev(EV_PULSE, {6'd0, done_pulse, timeout_pulse});
      if (pg != 2'b00 && grant == 2'b00) check_ev(EV_REL, 8'd0);
      pg = grant; pc = core_choose;
    end
  endtask

  task automatic driver();
    session(1'b1, 0, 1, 8'd10, 8'd0, 8'd0, 0, 0, 0, 4'd1, 1, 1, 1'b0);
    session(1'b1, 0, 2, 8'd5, 8'd10, 8'd0, 0, 0, 1, 4'd0, 1, 1, 1'b0);
    session(1'b0, 0, 3, 8'd10, 8'd1, 8'd10, 0, 1, 0, 4'd3, 3, 2, 1'b0);
    session(1'b0, 0, 1, 8'd10, 8'd0, 8'd0, 0, 0, 2, 4'd0, 1, 1, 1'b0);
    session(1'b0, 1, 1, 8'd10, 8'd0, 8'd0, 0, 0, 0, 4'd4, 1, WAIT_LIMIT + 1, 1'b0);
    session(1'b0, 0, 2, 8'd50, 8'd50, 8'd0, 0, TIMEOUT - 1, 0, 4'd2, 2, WAIT_LIMIT, 1'b0);
    session(1'b0, 1, 1, 8'd1, 8'd0, 8'd0, 0, 0, 2, 4'd0, 1, 1, 1'b1);
    session(1'b0, 0, 2, 8'd5, 8'd5, 8'd0, 1, 2, 1, 4'd0, 1, 3, 1'b1);
    for (int n = 0; n < 40; n++) begin
      session(1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(1, 3),
              pick_coin(), pick_coin(), pick_coin(), 2, $urandom_range(0, TIMEOUT - 1),
              $urandom_range(0, 2), 4'($urandom_range(1, 4)), $urandom_range(1, 3),
              $urandom_range(1, WAIT_LIMIT + 1), 1'($urandom_range(0, 1)));
    end
    // reset dropped in the middle of a panel 0 session
    drive(0, 8'd10, 4'd0);
    push(EV_GRANT, grant_code(0), cyc + 1);
    push(EV_MONEY, 8'd10, cyc + 1);
    step();
    drive(0, 8'd5, 4'd0);
    push(EV_MONEY, 8'd5, cyc + 1);
    step();
    drive(0, 8'd0, 4'd0);
    @(negedge clk);
    #1;
    push(EV_REL, 8'd0, cyc + 1);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    last_own = 1;
    session(1'b0, 1, 2, 8'd10, 8'd5, 8'd0, 0, 0, 0, 4'd2, 1, 1, 1'b0);
    session(1'b1, 0, 1, 8'd1, 8'd0, 8'd0, 0, 0, 0, 4'd3, 1, 2, 1'b0);
    repeat (3) step();
    drv_done = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    fork
      monitor();
      driver();
    join
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d expected events never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
